// File: rtl/divider_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_iter: iterative restoring divider, STEP quotient bits per clock,
// signed/unsigned, divide-by-zero/overflow flags, abort, tag. Rev 1.0
// ---------------------------------------------------------------------------
module divider_iter #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int STEP  = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     quotient,
  output logic [M-1:0]     remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int               CNT_W = $clog2(N / STEP + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(N / STEP);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [N-1:0]     r_dq, w_dq, w_step_dq;
  logic [M:0]       r_pr, w_pr, w_step_pr;
  logic [M-1:0]     r_dvs, w_dvs;
  logic [TAG_W-1:0] r_tag, w_tag;
  logic             r_qneg, w_qneg, r_rneg, w_rneg, r_ovf, w_ovf;

  logic             w_out_valid, w_div_zero, w_overflow;
  logic [N-1:0]     w_quotient;
  logic [M-1:0]     w_remainder;
  logic [TAG_W-1:0] w_out_tag;

  logic             w_dvd_neg, w_dvs_neg, w_flush, w_accept, w_ovf_in;
  logic [N-1:0]     w_dvd_mag;
  logic [M-1:0]     w_dvs_mag;

  assign w_dvd_neg = in_signed & dividend[N-1];
  assign w_dvs_neg = in_signed & divisor[M-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
  assign w_ovf_in  = in_signed & (dividend == {1'b1, {(N-1){1'b0}}}) & (&divisor);

  assign busy     = (r_state != IDLE);
  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_flush  = abort & busy;
  assign w_accept = in_valid & in_ready & ~w_flush;

  // r_dq shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    w_step_pr = r_pr;
    w_step_dq = r_dq;
    for (int i = 0; i < STEP; i++) begin
      w_step_pr = {w_step_pr[M-1:0], w_step_dq[N-1]};
      if (w_step_pr >= {1'b0, r_dvs}) begin
        w_step_pr = w_step_pr - {1'b0, r_dvs};
        w_step_dq = {w_step_dq[N-2:0], 1'b1};
      end else begin
        w_step_dq = {w_step_dq[N-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_dq        = r_dq;
    w_pr        = r_pr;
    w_dvs       = r_dvs;
    w_tag       = r_tag;
    w_qneg      = r_qneg;
    w_rneg      = r_rneg;
    w_ovf       = r_ovf;
    w_out_valid = out_valid;
    w_quotient  = quotient;
    w_remainder = remainder;
    w_out_tag   = out_tag;
    w_div_zero  = div_zero;
    w_overflow  = overflow;

    if (out_valid && out_ready) begin
      w_state     = IDLE;
      w_out_valid = 1'b0;
      w_quotient  = '0;
      w_remainder = '0;
      w_out_tag   = '0;
      w_div_zero  = 1'b0;
      w_overflow  = 1'b0;
    end

    if (r_state == CALC) begin
      w_dq  = w_step_dq;
      w_pr  = w_step_pr;
      w_cnt = r_cnt - ONE;
      if (r_cnt == ONE) begin
        w_state     = DONE;
        w_out_valid = 1'b1;
        w_quotient  = r_qneg ? -w_step_dq : w_step_dq;
        w_remainder = r_rneg ? -w_step_pr[M-1:0] : w_step_pr[M-1:0];
        w_out_tag   = r_tag;
        w_div_zero  = 1'b0;
        w_overflow  = r_ovf;
      end
    end

    if (w_accept) begin
      w_tag = in_tag;
      if (divisor == '0) begin
        w_state     = DONE;
        w_out_valid = 1'b1;
        w_quotient  = '1;
        w_remainder = dividend[M-1:0];
        w_out_tag   = in_tag;
        w_div_zero  = 1'b1;
        w_overflow  = 1'b0;
      end else begin
        w_state = CALC;
        w_cnt   = ITERS;
        w_dq    = w_dvd_mag;
        w_pr    = '0;
        w_dvs   = w_dvs_mag;
        w_qneg  = w_dvd_neg ^ w_dvs_neg;
        w_rneg  = w_dvd_neg;
        w_ovf   = w_ovf_in;
      end
    end

    if (w_flush) begin
      w_state     = IDLE;
      w_out_valid = 1'b0;
      w_quotient  = '0;
      w_remainder = '0;
      w_out_tag   = '0;
      w_div_zero  = 1'b0;
      w_overflow  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dq      <= '0;
      r_pr      <= '0;
      r_dvs     <= '0;
      r_tag     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      out_tag   <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_dq      <= w_dq;
      r_pr      <= w_pr;
      r_dvs     <= w_dvs;
      r_tag     <= w_tag;
      r_qneg    <= w_qneg;
      r_rneg    <= w_rneg;
      r_ovf     <= w_ovf;
      out_valid <= w_out_valid;
      quotient  <= w_quotient;
      remainder <= w_remainder;
      out_tag   <= w_out_tag;
      div_zero  <= w_div_zero;
      overflow  <= w_overflow;
    end
  end

endmodule
`default_nettype wire
